// File: rtl/spi_bus_arb.sv
// spi_bus_arb
// Shares one SPI monarch between two requesters: 0 is the inertial sequencer
// and 1 is the A2D sampler. Each requester's command word is buffered on a
// one-cycle request pulse. The arbiter then launches frames on the monarch,
// alternating between requesters when both are waiting. A requester holding
// its lock line keeps the bus between frames until the lock drops or the
// idle hold budget (HOLD_TO cycles) runs out.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req0/req1                  one-cycle request pulses
//   wrt_data0/wrt_data1 [15:0] command words, sampled with the request pulse
//   lock0/lock1                keep-bus level from each requester
//   done0/done1                one-cycle completion pulse per requester
//   rd_data [15:0]             last received word, held between frames
//   mnrch_wrt                  one-cycle frame launch to the monarch
//   mnrch_wrt_data [15:0]      command word for the launched frame
//   mnrch_done                 frame-complete strobe from the monarch
//   mnrch_rd_data [15:0]       word received by the monarch
//   mnrch_SS_n                 monarch's slave select
//   SS0_n/SS1_n                per-device slave selects routed from mnrch_SS_n
module spi_bus_arb #(
  parameter int HOLD_TO = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] wrt_data0,
  input  logic [15:0] wrt_data1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rd_data,
  output logic        mnrch_wrt,
  output logic [15:0] mnrch_wrt_data,
  input  logic        mnrch_done,
  input  logic [15:0] mnrch_rd_data,
  input  logic        mnrch_SS_n,
  output logic        SS0_n,
  output logic        SS1_n
);

  localparam int CNT_W = (HOLD_TO < 1) ? 1 : $clog2(HOLD_TO + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_TO);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  state_t           state_q;
  logic             pend0_q, pend1_q;
  logic [15:0]      buf0_q, buf1_q;
  logic             owner_q;
  logic             rr_last_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  logic             mnrch_wrt_q;
  logic [15:0]      mnrch_wrt_data_q;
  logic             done0_q, done1_q;
  logic [15:0]      rd_data_q;

  logic grant0, grant1, hold_exit, lock_own, pend_own;

  // Grant decision. In IDLE the requester that was not served last wins a
  // tie. In HOLD only the owner can be granted, and an exit (lock dropped
  // or budget spent) takes precedence so arbitration restarts fairly.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    hold_exit  = 1'b0;
    lock_own   = owner_q ? lock1 : lock0;
    pend_own   = owner_q ? pend1_q : pend0_q;
    hold_cnt_d = hold_cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (pend0_q && pend1_q) begin
          grant0 = rr_last_q;
          grant1 = !rr_last_q;
        end else begin
          grant0 = pend0_q;
          grant1 = pend1_q;
        end
      end
      HOLD: begin
        hold_exit = !lock_own || (hold_cnt_d >= HOLD_MAX);
        if (!hold_exit && pend_own) begin
          grant0 = !owner_q;
          grant1 = owner_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      pend0_q          <= 1'b0;
      pend1_q          <= 1'b0;
      buf0_q           <= '0;
      buf1_q           <= '0;
      owner_q          <= 1'b0;
      rr_last_q        <= 1'b1;
      hold_cnt_q       <= '0;
      mnrch_wrt_q      <= 1'b0;
      mnrch_wrt_data_q <= '0;
      done0_q          <= 1'b0;
      done1_q          <= 1'b0;
      rd_data_q        <= '0;
    end else begin
      mnrch_wrt_q <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;

      // A request landing on the grant cycle re-arms the slot being freed.
      if (req0 && (!pend0_q || grant0)) begin
        pend0_q <= 1'b1;
        buf0_q  <= wrt_data0;
      end else if (grant0) begin
        pend0_q <= 1'b0;
      end
      if (req1 && (!pend1_q || grant1)) begin
        pend1_q <= 1'b1;
        buf1_q  <= wrt_data1;
      end else if (grant1) begin
        pend1_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            mnrch_wrt_q      <= 1'b1;
            mnrch_wrt_data_q <= grant1 ? buf1_q : buf0_q;
            owner_q          <= grant1;
            state_q          <= BUSY;
          end
        end
        BUSY: begin
          if (mnrch_done) begin
            rd_data_q  <= mnrch_rd_data;
            done0_q    <= !owner_q;
            done1_q    <= owner_q;
            rr_last_q  <= owner_q;
            hold_cnt_q <= '0;
            state_q    <= lock_own ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (hold_exit) begin
            state_q <= IDLE;
          end else if (grant0 || grant1) begin
            mnrch_wrt_q      <= 1'b1;
            mnrch_wrt_data_q <= grant1 ? buf1_q : buf0_q;
            owner_q          <= grant1;
            state_q          <= BUSY;
          end else begin
            hold_cnt_q <= hold_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mnrch_wrt      = mnrch_wrt_q;
  assign mnrch_wrt_data = mnrch_wrt_data_q;
  assign done0          = done0_q;
  assign done1          = done1_q;
  assign rd_data        = rd_data_q;

  // Slave selects follow the monarch live so framing edges are not delayed.
  assign SS0_n = (state_q != IDLE && owner_q == 1'b0) ? mnrch_SS_n : 1'b1;
  assign SS1_n = (state_q != IDLE && owner_q == 1'b1) ? mnrch_SS_n : 1'b1;

endmodule
